// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types for the bit-serial subtractor
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full-subtractor cell
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    // borrow out when x < y + bi for single bits
    always_comb begin
        diff = x ^ y ^ bi;
        bo   = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one cell
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             cell_diff;
    logic             cell_bo;

    full_subtractor u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bi   (borrow),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    // in_ready is gated by rst so it is low for as long as reset is held
    always_comb begin
        in_ready = (state == IDLE) && !rst;
        busy     = (state != IDLE);
    end

    // FSM, operand/result shift registers, bit counter and borrow chain
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            sr        <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sr     <= {cell_diff, sr[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    // the last bit goes straight into the held result so
                    // d/bout only move on the edge that enters DONE
                    if (cnt == LAST_BIT) begin
                        d         <= {cell_diff, sr[WIDTH-1:1]};
                        bout      <= cell_bo;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;

    int checks;
    int failures;
    logic [W:0] sb_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tbin, input int hold, input bit pulse);
        int n;
        logic [W:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        in_valid = 1'b1;
        sb_q.push_back({1'b0, ta} - {1'b0, tb_v} - (W+1)'(tbin));
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            if (pulse && n == 3) begin
                in_valid = 1'b1;
                a        = 8'hAA;
            end
            tick();
            in_valid = 1'b0;
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
        chk("d", 32'(d), 32'(e[W-1:0]));
        chk("bout", 32'(bout), 32'(e[W]));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_d", 32'(d), 32'(e[W-1:0]));
            chk("hold_bout", 32'(bout), 32'(e[W]));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 5, 1'b0);
        do_op(8'h33, 8'h11, 1'b0, 0, 1'b1);

        // abort in the middle of RUN
        a        = 8'h55;
        b        = 8'h11;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_run_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_rel", 32'(in_ready), 32'd1);
        do_op(8'h10, 8'h01, 1'b0, 0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
